// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Control sequencer for a word-serial AES encryption datapath. It holds the
// 128-bit cipher state, walks the round counter 0..Nr and the 32-bit word
// index 0..3 inside each round, and reloads the state from the downstream
// round-data stage at the end of LOAD and of every round.
//
// Parameters
//   NR_128, NR_192, NR_256 : round counts for mode 00, 01 and 10
//
// Ports
//   clk          in   1    rising-edge clock
//   reset        in   1    synchronous, active-high reset
//   start        in   1    encrypt request, only looked at in IDLE
//   mode         in   2    00 AES-128, 01 AES-192, 10 AES-256, 11 illegal
//   block_in     in   128  plaintext, captured on an accepted start
//   round_result in   128  data_out of the round-data stage
//   ready        out  1    high only in IDLE
//   round        out  4    current round number
//   width_sel    out  2    current 32-bit word index
//   mode_out     out  2    mode latched at start
//   state_out    out  128  cipher state register
//   done         out  1    one-cycle completion pulse
//   block_out    out  128  ciphertext, held until the next accepted start
//   mode_err     out  1    one-cycle pulse on a start with mode 11
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR_128 = 10,
    parameter int NR_192 = 12,
    parameter int NR_256 = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [127:0] block_in,
    input  logic [127:0] round_result,
    output logic         ready,
    output logic [3:0]   round,
    output logic [1:0]   width_sel,
    output logic [1:0]   mode_out,
    output logic [127:0] state_out,
    output logic         done,
    output logic [127:0] block_out,
    output logic         mode_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t           fsm_q;
    fsm_t           fsm_d;
    logic [3:0]     round_q;
    logic [3:0]     nr_q;
    logic [1:0]     wsel_q;
    logic [1:0]     mode_q;
    logic [127:0]   state_q;
    logic [127:0]   bout_q;
    logic           err_q;
    logic           accept;
    logic           last_word;

    function automatic logic [3:0] nr_for_mode(input logic [1:0] m);
        case (m)
            2'b00:   nr_for_mode = 4'(NR_128);
            2'b01:   nr_for_mode = 4'(NR_192);
            default: nr_for_mode = 4'(NR_256);
        endcase
    endfunction

    assign accept    = (fsm_q == IDLE) && start && (mode != 2'b11);
    assign last_word = (wsel_q == 2'd3);

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (accept) fsm_d = LOAD;
            LOAD:    fsm_d = ROUND;
            ROUND:   if (last_word && (round_q == nr_q)) fsm_d = DONE;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    // Datapath and counters. Round and word index are forced back to 0 when
    // the last round completes so that DONE and IDLE present 0 on both.
    always_ff @(posedge clk) begin
        if (reset) begin
            round_q <= 4'd0;
            nr_q    <= 4'd0;
            wsel_q  <= 2'd0;
            mode_q  <= 2'b00;
            state_q <= '0;
            bout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        if (mode == 2'b11) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= block_in;
                            mode_q  <= mode;
                            nr_q    <= nr_for_mode(mode);
                            round_q <= 4'd0;
                            wsel_q  <= 2'd0;
                        end
                    end
                end
                LOAD: begin
                    state_q <= round_result;
                    round_q <= 4'd1;
                    wsel_q  <= 2'd0;
                end
                ROUND: begin
                    // The downstream accumulator has no enable, so the word
                    // index free-runs 0..3 and the state only moves on word 3.
                    if (last_word) begin
                        state_q <= round_result;
                        wsel_q  <= 2'd0;
                        if (round_q == nr_q) begin
                            bout_q  <= round_result;
                            round_q <= 4'd0;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end else begin
                        wsel_q <= wsel_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (fsm_q == IDLE);
    assign done      = (fsm_q == DONE);
    assign round     = round_q;
    assign width_sel = wsel_q;
    assign mode_out  = mode_q;
    assign state_out = state_q;
    assign block_out = bout_q;
    assign mode_err  = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Bench for aes_round_sequencer with a stub round stage:
//   round_result = state_out ^ {124'b0, round}
// so the final ciphertext is block_in ^ (1 ^ 2 ^ ... ^ Nr).
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [127:0] block_in;
    logic [127:0] round_result;
    logic         ready;
    logic [3:0]   round;
    logic [1:0]   width_sel;
    logic [1:0]   mode_out;
    logic [127:0] state_out;
    logic         done;
    logic [127:0] block_out;
    logic         mode_err;

    int errors = 0;
    int checks = 0;

    aes_round_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .block_in     (block_in),
        .round_result (round_result),
        .ready        (ready),
        .round        (round),
        .width_sel    (width_sel),
        .mode_out     (mode_out),
        .state_out    (state_out),
        .done         (done),
        .block_out    (block_out),
        .mode_err     (mode_err)
    );

    assign round_result = state_out ^ {124'b0, round};

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [127:0] blk;
        int           lat;
        logic [127:0] exp_out;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE. Drives start, then follows
    // the operation cycle by cycle up to the first IDLE cycle after DONE.
    task automatic run_op(input string name, input logic [1:0] m, input logic [127:0] b,
                          input int lat, input logic [127:0] exp_out,
                          input bit hold_start, input bit scramble);
        logic [127:0] exp_state;
        logic [3:0]   exp_round;
        logic [1:0]   exp_ws;
        bit           pat_ok;
        int           done_cyc;
        chk({name, " ready_before"}, 128'(ready), 128'(1'b1));
        start     = 1'b1;
        mode      = m;
        block_in  = b;
        exp_state = b;
        pat_ok    = 1'b1;
        done_cyc  = -1;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !hold_start) start = 1'b0;
            if (cyc >= 2 && cyc <= lat - 1) begin
                exp_round = 4'((cyc - 2) / 4 + 1);
                exp_ws    = 2'((cyc - 2) % 4);
            end else begin
                exp_round = 4'd0;
                exp_ws    = 2'd0;
            end
            if (round !== exp_round || width_sel !== exp_ws || state_out !== exp_state ||
                ready !== 1'b0 || done !== (cyc == lat))
                pat_ok = 1'b0;
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (cyc >= 2 && cyc <= lat - 1 && exp_ws == 2'd3)
                exp_state = exp_state ^ {124'b0, exp_round};
            if (scramble && cyc >= 2) begin
                block_in = {$urandom, $urandom, $urandom, $urandom};
                mode     = 2'($urandom);
            end
        end
        chk({name, " done_cycle"}, 128'(done_cyc), 128'(lat));
        chk({name, " sequence"}, 128'(pat_ok), 128'(1'b1));
        chk({name, " block_out"}, block_out, exp_out);
        chk({name, " mode_out"}, 128'(mode_out), 128'(m));
        @(negedge clk);
        chk({name, " done_width"}, 128'(done), 128'(1'b0));
        chk({name, " ready_after"}, 128'(ready), 128'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0] = '{2'b00, 128'h00112233445566778899aabbccddeeff, 42, 128'h00112233445566778899aabbccddeef4};
        tbl[1] = '{2'b01, 128'h0,                                50, 128'h0000000000000000000000000000000c};
        tbl[2] = '{2'b10, {128{1'b1}},                           58, 128'hfffffffffffffffffffffffffffffff0};
        tbl[3] = '{2'b00, 128'h0123456789abcdef0123456789abcdef, 42, 128'h0123456789abcdef0123456789abcde4};

        // Reset with start asserted: reset wins
        reset    = 1'b1;
        start    = 1'b1;
        mode     = 2'b00;
        block_in = 128'hdead;
        repeat (3) @(negedge clk);
        chk("rst ready",     128'(ready),     128'(1'b1));
        chk("rst round",     128'(round),     128'(0));
        chk("rst width_sel", 128'(width_sel), 128'(0));
        chk("rst mode_out",  128'(mode_out),  128'(0));
        chk("rst state_out", state_out,       128'(0));
        chk("rst block_out", block_out,       128'(0));
        chk("rst done",      128'(done),      128'(0));
        chk("rst mode_err",  128'(mode_err),  128'(0));
        reset = 1'b0;

        // First start accepted right after reset release
        for (int i = 0; i < 4; i++)
            run_op($sformatf("vec%0d", i), tbl[i].mode, tbl[i].blk, tbl[i].lat, tbl[i].exp_out, 1'b0, 1'b0);

        // Illegal mode: pulse only, nothing else moves
        start = 1'b1;
        mode  = 2'b11;
        @(negedge clk);
        start = 1'b0;
        chk("illegal mode_err",  128'(mode_err),  128'(1'b1));
        chk("illegal ready",     128'(ready),     128'(1'b1));
        chk("illegal round",     128'(round),     128'(0));
        chk("illegal state_out", state_out,       tbl[3].exp_out);
        chk("illegal block_out", block_out,       tbl[3].exp_out);
        chk("illegal mode_out",  128'(mode_out),  128'(2'b00));
        @(negedge clk);
        chk("illegal pulse_width", 128'(mode_err), 128'(1'b0));

        // Back-to-back with start held; block_in/mode scrambled while busy
        run_op("b2b0", 2'b00, 128'h55, 42, 128'h5e, 1'b1, 1'b1);
        run_op("b2b1", 2'b00, 128'haa, 42, 128'ha1, 1'b1, 1'b1);
        start = 1'b0;

        // Reset in the middle of an AES-192 operation
        start    = 1'b1;
        mode     = 2'b01;
        block_in = 128'h1234;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(round == 4'd6 && width_sel == 2'd2) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("midrst reached", 128'(n < 60), 128'(1'b1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst ready",     128'(ready),     128'(1'b1));
        chk("midrst round",     128'(round),     128'(0));
        chk("midrst width_sel", 128'(width_sel), 128'(0));
        chk("midrst block_out", block_out,       128'(0));
        chk("midrst state_out", state_out,       128'(0));
        run_op("after_rst", 2'b01, 128'h1234, 50, 128'h1238, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
